// File: rtl/c_wf_req_queue.sv
// c_wf_req_queue: requester-side companion to the wavefront switch allocator.
// Each input port queues pending output destinations in a small circular FIFO
// and presents its head as one one-hot row of the allocator request matrix.
// Grants pop the matching heads, drive the allocator priority update strobe
// and are echoed back one cycle later as registered per-port notifications.
// Build option: define C_WF_REQ_QUEUE_CHECK_EN to compile in the protocol
// checker and the sticky error flag (otherwise error is tied low).
module c_wf_req_queue #(
    parameter int  num_ports      = 8,
    parameter int  queue_depth    = 4,
    parameter int  max_wait       = 15,
    parameter int  reset_type     = 0,   // 0 = RESET_TYPE_ASYNC
    localparam int port_idx_width = $clog2(num_ports),
    localparam int wait_width     = $clog2(max_wait + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                active,
    input  logic [num_ports-1:0]                push_valid,
    input  logic [num_ports*port_idx_width-1:0] push_dest,
    output logic [num_ports-1:0]                push_ready,
    output logic [num_ports*num_ports-1:0]      req,
    input  logic [num_ports*num_ports-1:0]      gnt,
    output logic                                update,
    output logic [num_ports-1:0]                grant_valid,
    output logic [num_ports*port_idx_width-1:0] grant_dest,
    output logic [num_ports-1:0]                starve,
    output logic                                error
);

    localparam int PTR_W = (queue_depth > 1) ? $clog2(queue_depth) : 1;
    localparam int CNT_W = $clog2(queue_depth + 1);
    localparam int PW    = port_idx_width;

    localparam logic [CNT_W-1:0]      DEPTH    = CNT_W'(queue_depth);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(queue_depth - 1);
    localparam logic [wait_width-1:0] WAIT_MAX = wait_width'(max_wait);
    localparam logic [wait_width-1:0] WAIT_ONE = wait_width'(1);
    localparam logic [num_ports-1:0]  ROW_ONE  = {{(num_ports-1){1'b0}}, 1'b1};

    // Only the asynchronous reset flavour exists; every reset_type value
    // elaborates to the same asynchronously reset flops.
    if (reset_type != 0) begin : g_reset_type_async_only
    end

    logic [PW-1:0]          r_mem      [num_ports][queue_depth];
    logic [PTR_W-1:0]       r_rd_ptr   [num_ports];
    logic [PTR_W-1:0]       r_wr_ptr   [num_ports];
    logic [CNT_W-1:0]       r_count    [num_ports];
    logic [wait_width-1:0]  r_wait     [num_ports];
    logic [num_ports-1:0]   r_grant_valid;
    logic [num_ports*PW-1:0] r_grant_dest;

    logic [PW-1:0]                w_head [num_ports];
    logic [num_ports*num_ports-1:0] w_req;
    logic [num_ports-1:0]         w_ready;
    logic [num_ports-1:0]         w_pop;
    logic [num_ports-1:0]         w_push;
    logic [num_ports-1:0]         w_starve;

    // Head decode, request rows, and qualified push/pop strobes per port
    always_comb begin
        w_req   = '0;
        w_ready = '0;
        w_pop   = '0;
        w_push  = '0;
        for (int i = 0; i < num_ports; i++) begin
            w_head[i]  = r_mem[i][r_rd_ptr[i]];
            w_ready[i] = (r_count[i] != DEPTH);
            if (r_count[i] != '0)
                w_req[i*num_ports +: num_ports] = ROW_ONE << w_head[i];
            // req is built from registered state only, so no gnt->req loop
            w_pop[i]  = active & (|(gnt[i*num_ports +: num_ports] & w_req[i*num_ports +: num_ports]));
            w_push[i] = active & push_valid[i] & w_ready[i];
        end
    end

    // FIFO storage is written on accepted pushes; empty slots need no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < num_ports; i++) begin
            if (w_push[i])
                r_mem[i][r_wr_ptr[i]] <= push_dest[i*PW +: PW];
        end
    end

    // Pointers, occupancy, wait counters and registered grant notifications
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_ports; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
                r_wait[i]   <= '0;
            end
            r_grant_valid <= '0;
            r_grant_dest  <= '0;
        end else if (active) begin
            for (int i = 0; i < num_ports; i++) begin
                // explicit compare-and-clear keeps non-power-of-two depths correct
                if (w_push[i])
                    r_wr_ptr[i] <= (r_wr_ptr[i] == PTR_LAST) ? '0 : r_wr_ptr[i] + PTR_ONE;
                if (w_pop[i])
                    r_rd_ptr[i] <= (r_rd_ptr[i] == PTR_LAST) ? '0 : r_rd_ptr[i] + PTR_ONE;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
                    2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
                    default: r_count[i] <= r_count[i];
                endcase
                if (w_pop[i] || (r_count[i] == '0))
                    r_wait[i] <= '0;
                else if (r_wait[i] != WAIT_MAX)
                    r_wait[i] <= r_wait[i] + WAIT_ONE;
                r_grant_valid[i]          <= w_pop[i];
                r_grant_dest[i*PW +: PW]  <= w_pop[i] ? w_head[i] : '0;
            end
        end
    end

    // Starvation flag per port
    always_comb begin
        w_starve = '0;
        for (int i = 0; i < num_ports; i++)
            w_starve[i] = (r_wait[i] == WAIT_MAX);
    end

    assign push_ready  = w_ready;
    assign req         = w_req;
    assign update      = active & (|(gnt & w_req));
    assign grant_valid = r_grant_valid;
    assign grant_dest  = r_grant_dest;
    assign starve      = w_starve;

`ifdef C_WF_REQ_QUEUE_CHECK_EN
    logic [num_ports-1:0] w_gnt_col [num_ports];
    logic                 w_violation;
    logic                 r_error;

    function automatic logic f_multi_hot(input logic [num_ports-1:0] v);
        return (v & (v - ROW_ONE)) != '0;
    endfunction

    // Transpose the grant matrix so columns can be checked like rows
    always_comb begin
        for (int j = 0; j < num_ports; j++) begin
            w_gnt_col[j] = '0;
            for (int i = 0; i < num_ports; i++)
                w_gnt_col[j][i] = gnt[i*num_ports + j];
        end
    end

    // Protocol violations: unrequested grant, multi-grant row/column, overflow
    always_comb begin
        w_violation = |(gnt & ~w_req);
        for (int i = 0; i < num_ports; i++) begin
            if (f_multi_hot(gnt[i*num_ports +: num_ports])) w_violation = 1'b1;
            if (f_multi_hot(w_gnt_col[i]))                 w_violation = 1'b1;
            if (push_valid[i] && !w_ready[i])               w_violation = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_error <= 1'b0;
        else if (active && w_violation)
            r_error <= 1'b1;
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_c_wf_req_queue.sv
// Self-checking bench for c_wf_req_queue (4 ports, depth 2, max_wait 15).
// A queue-based reference model is compared against every output on every
// falling edge; directed scenarios add hand-computed literal expectations.
module tb_c_wf_req_queue;

    localparam int NP   = 4;
    localparam int D    = 2;
    localparam int MAXW = 15;
    localparam int PW   = 2;
`ifdef C_WF_REQ_QUEUE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              active = 1'b0;
    logic [NP-1:0]     push_valid = '0;
    logic [NP*PW-1:0]  push_dest = '0;
    logic [NP-1:0]     push_ready;
    logic [NP*NP-1:0]  req;
    logic [NP*NP-1:0]  gnt = '0;
    logic              update;
    logic [NP-1:0]     grant_valid;
    logic [NP*PW-1:0]  grant_dest;
    logic [NP-1:0]     starve;
    logic              error;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int mq [NP][$];
    int mw [NP];
    bit mgv [NP];
    int mgd [NP];
    bit merr;

    c_wf_req_queue #(
        .num_ports   (NP),
        .queue_depth (D),
        .max_wait    (MAXW),
        .reset_type  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .push_valid  (push_valid),
        .push_dest   (push_dest),
        .push_ready  (push_ready),
        .req         (req),
        .gnt         (gnt),
        .update      (update),
        .grant_valid (grant_valid),
        .grant_dest  (grant_dest),
        .starve      (starve),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            mw[i]  = 0;
            mgv[i] = 1'b0;
            mgd[i] = 0;
        end
        merr = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [NP-1:0]    e_ready, e_starve, e_gv;
        logic [NP*NP-1:0] e_req;
        logic [NP*PW-1:0] e_gd;
        logic             e_upd;
        e_ready = '0; e_starve = '0; e_gv = '0; e_req = '0; e_gd = '0; e_upd = 1'b0;
        for (int i = 0; i < NP; i++) begin
            e_ready[i] = (mq[i].size() < D);
            if (mq[i].size() > 0) begin
                e_req[i*NP + mq[i][0]] = 1'b1;
                if (gnt[i*NP + mq[i][0]]) e_upd = active;
            end
            e_starve[i] = (mw[i] == MAXW);
            e_gv[i] = mgv[i];
            e_gd[i*PW +: PW] = mgd[i][PW-1:0];
        end
        chk("push_ready", push_ready, e_ready);
        chk("req", req, e_req);
        chk("update", update, e_upd);
        chk("starve", starve, e_starve);
        chk("grant_valid", grant_valid, e_gv);
        chk("grant_dest", grant_dest, e_gd);
        chk("error", error, CHK & merr);
    endtask

    task automatic model_advance();
        bit hit [NP];
        int cnt;
        for (int i = 0; i < NP; i++)
            for (int j = 0; j < NP; j++)
                if (gnt[i*NP + j] && !(mq[i].size() > 0 && mq[i][0] == j)) merr = 1'b1;
        for (int i = 0; i < NP; i++) begin
            cnt = 0;
            for (int j = 0; j < NP; j++) cnt += int'(gnt[i*NP + j]);
            if (cnt > 1) merr = 1'b1;
            cnt = 0;
            for (int j = 0; j < NP; j++) cnt += int'(gnt[j*NP + i]);
            if (cnt > 1) merr = 1'b1;
        end
        for (int i = 0; i < NP; i++) begin
            int sz0;
            sz0    = mq[i].size();
            hit[i] = (sz0 > 0) && gnt[i*NP + mq[i][0]];
            mgv[i] = hit[i];
            mgd[i] = hit[i] ? mq[i][0] : 0;
            if (hit[i] || sz0 == 0) mw[i] = 0;
            else if (mw[i] < MAXW) mw[i] = mw[i] + 1;
            if (hit[i]) void'(mq[i].pop_front());
            if (push_valid[i]) begin
                if (sz0 < D) mq[i].push_back(int'(push_dest[i*PW +: PW]));
                else merr = 1'b1;
            end
        end
    endtask

    // Single compare process: check against the model, then step it
    always @(negedge clk) begin
        if (!reset) model_clear();
        compare_outputs();
        if (reset && active) model_advance();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [NP*NP-1:0] gnt_v;
        logic [NP-1:0]    used;
        int st, idx;

        // reset and idle
        repeat (2) tick();
        look();
        chk("rst_push_ready", push_ready, 4'b1111);
        chk("rst_req", req, 16'h0000);
        chk("rst_grant_valid", grant_valid, 4'b0000);
        chk("rst_starve", starve, 4'b0000);
        chk("rst_error", error, 1'b0);
        tick();
        reset  = 1'b1;
        active = 1'b1;
        tick();

        // port 1 pushes dest 2, granted next cycle
        push_valid = 4'b0010; push_dest = 8'h08;
        tick();
        push_valid = '0; gnt = 16'h0040;
        look();
        chk("t1_req_1_2", req[6], 1'b1);
        chk("t1_update", update, 1'b1);
        tick();
        gnt = '0;
        look();
        chk("t2_grant_valid", grant_valid, 4'b0010);
        chk("t2_grant_dest_p1", grant_dest[3:2], 2'd2);
        chk("t2_req_row1", req[7:4], 4'b0000);
        tick();

        // fill port 0 with 3,1; third push overflows; drain in order
        push_valid = 4'b0001; push_dest = 8'h03;
        tick();
        push_dest = 8'h01;
        tick();
        push_dest = 8'h02;
        look();
        chk("full_push_ready0", push_ready[0], 1'b0);
        tick();
        push_valid = '0; gnt = 16'h0008;
        look();
        chk("ovf_error", error, CHK);
        chk("ovf_head3", req[3:0], 4'b1000);
        tick();
        gnt = 16'h0002;
        look();
        chk("drain_first", grant_dest[1:0], 2'd3);
        chk("drain_next_head", req[3:0], 4'b0010);
        tick();
        gnt = '0;
        look();
        chk("drain_second", grant_dest[1:0], 2'd1);
        chk("drain_empty", req[3:0], 4'b0000);
        tick();

        // reset mid-operation with a grant pending
        push_valid = 4'b1000; push_dest = 8'h40;
        tick();
        push_valid = '0; gnt = 16'h2000;
        #2 reset = 1'b0;
        look();
        chk("midrst_req", req, 16'h0000);
        chk("midrst_update", update, 1'b0);
        chk("midrst_error", error, 1'b0);
        tick();
        gnt = '0; reset = 1'b1;
        look();
        chk("midrst_no_pulse", grant_valid, 4'b0000);
        tick();

        // unrequested grant on an empty row
        gnt = 16'h0001;
        look();
        chk("bad_gnt_update", update, 1'b0);
        tick();
        gnt = '0;
        look();
        chk("bad_gnt_error", error, CHK);
        chk("bad_gnt_ready", push_ready, 4'b1111);
        chk("bad_gnt_gv", grant_valid, 4'b0000);
        tick();

        // starvation on port 3 (dest 0)
        push_valid = 4'b1000; push_dest = 8'h00;
        tick();
        push_valid = '0;
        repeat (14) tick();
        look();
        chk("starve_c15", starve[3], 1'b0);
        tick();
        look();
        chk("starve_c16", starve[3], 1'b1);
        tick();
        gnt = 16'h1000;
        look();
        chk("starve_held", starve[3], 1'b1);
        tick();
        gnt = '0;
        look();
        chk("starve_cleared", starve[3], 1'b0);
        chk("starve_gv", grant_valid, 4'b1000);
        tick();

        // push and grant on a full port 2 in the same cycle
        push_valid = 4'b0100; push_dest = 8'h10;
        tick();
        push_dest = 8'h30;
        tick();
        push_dest = 8'h00; gnt = 16'h0200;
        look();
        chk("full2_ready", push_ready[2], 1'b0);
        chk("full2_update", update, 1'b1);
        tick();
        push_valid = '0; gnt = '0;
        look();
        chk("full2_ready_after", push_ready[2], 1'b1);
        chk("full2_one_left", req[11:8], 4'b1000);
        chk("full2_gd", grant_dest[5:4], 2'd1);
        tick();
        gnt = 16'h0800;
        tick();
        gnt = '0;
        look();
        chk("full2_drained", req[11:8], 4'b0000);
        tick();

        // active low: grant_valid holds, pushes suppressed
        push_valid = 4'b0010; push_dest = 8'h00;
        tick();
        push_valid = '0; gnt = 16'h0010;
        tick();
        gnt = '0; active = 1'b0; push_valid = 4'b0001; push_dest = 8'h02;
        look();
        chk("idle_gv_hold", grant_valid, 4'b0010);
        chk("idle_update", update, 1'b0);
        tick();
        look();
        chk("idle_gv_hold2", grant_valid, 4'b0010);
        chk("idle_no_push", req[3:0], 4'b0000);
        tick();
        push_valid = '0; active = 1'b1;
        tick();

        // clear sticky error, then randomized traffic
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            active     = ($urandom_range(0, 7) != 0);
            push_valid = 4'($urandom);
            push_dest  = 8'($urandom);
            gnt_v = '0;
            used  = '0;
            st = $urandom_range(0, NP-1);
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (st + k) % NP;
                if (mq[i].size() > 0 && !used[mq[i][0]] && $urandom_range(0, 9) < 7) begin
                    gnt_v[i*NP + mq[i][0]] = 1'b1;
                    used[mq[i][0]] = 1'b1;
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                idx = $urandom_range(0, NP*NP-1);
                gnt_v[idx] = 1'b1;
            end
            gnt = gnt_v;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        push_valid = '0; gnt = '0; active = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
